adder_serial_32b_gl: RTL
========================

// Module: adder_serial_32b_gl
// PURPOSE
// - Multi-cycle WIDTH-bit adder built around one AdderCarrySelect_8b_GL instance.
// - Upstream sequencer for that adder: latches full-width operands, feeds one 8-bit
//   slice per cycle LSB-first, and chains each slice's cout into the next slice's cin.
// - Accumulates the sum slices into a result register.
// - val/rdy handshake on both sides; used where area matters more than ALU latency.
// PARAMETERS
// - WIDTH  default 32  operand/result width; must be a multiple of 8 and >= 16
// - NSLICE = WIDTH/8   localparam, cycles spent in CALC
// PORTS
// - clk      in   1      rising-edge clock
// - rst_n    in   1      asynchronous reset, active low
// - in_val   in   1      operands valid
// - in_rdy   out  1      block can accept operands
// - in0      in   WIDTH  operand A
// - in1      in   WIDTH  operand B
// - cin      in   1      carry-in for slice 0
// - sub      in   1      subtract request (only with ADDER_SERIAL_SUB_EN)
// - out_val  out  1      result valid
// - out_rdy  in   1      consumer accepts result
// - sum      out  WIDTH  registered result
// - cout     out  1      carry out of the MSB slice
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, slice index=0, carry=0, operand regs=0.
//   Reset values: sum=0, cout=0, out_val=0, in_rdy=1 once rst_n deasserts.
// - FSM states: IDLE, CALC, DONE.
// - IDLE: in_rdy=1, out_val=0. On in_val&&in_rdy at a clock edge:
//   - latch in0, in1, cin (and sub when enabled);
//   - clear sum; set idx=0; go to CALC.
// - CALC: in_rdy=0, out_val=0. Adder inputs are in0_r[8*idx+:8], in1_r[8*idx+:8],
//   and carry_r (cin_r when idx=0). Each edge:
//   - write the adder sum into sum[8*idx+:8] and adder cout into carry_r;
//   - idx++.
//   - The edge with idx==NSLICE-1 also loads cout and goes to DONE.
// - DONE: out_val=1, in_rdy=0. sum and cout are held stable while out_val=1 and
//   out_rdy=0. On out_rdy: go to IDLE. No new accept in the same cycle, so
//   throughput is one op per NSLICE+2 cycles minimum.
// - Latency: accept at edge E -> out_val high after edge E+NSLICE (4 edges for WIDTH=32).
// - Arithmetic: {cout,sum} = in0 + in1 + cin, mod 2^(WIDTH+1). No overflow flag.
// - Operand inputs changing while not in IDLE have no effect.
// - in_val held high in CALC/DONE is not consumed; it is accepted in IDLE.
// - Reset asserted mid-CALC or mid-DONE aborts the op immediately; the partial sum
//   is discarded (sum=0).
// - sum, cout, out_val and in_rdy are registered or pure state decodes.
//   No combinational path from in_val or out_rdy to any output.
// CONFIGURATION
// - ADDER_SERIAL_SUB_EN defined:
//   - the sub port exists and is latched at accept;
//   - when sub_r=1, slice operand B is ~in1_r slice and slice-0 carry-in is 1 (cin ignored);
//   - result = in0 - in1, cout=1 means no borrow.
// - Undefined: no sub port; add only; behaviour exactly as above.
// TESTING
// - 0x000000FF + 0x00000001, cin=0 -> sum=0x00000100, cout=0; out_val 4 edges after accept.
// - 0xFFFFFFFF + 0x00000000, cin=1 -> sum=0x00000000, cout=1 (carry ripples all 4 slices).
// - 0x80000000 + 0x80000000, cin=0 -> sum=0, cout=1.
//   Hold out_rdy=0 for 3 cycles: sum/cout/out_val stable, in_rdy=0 throughout.
// - Accept 0x12345678 + 0x11111111; toggle in0/in1 during CALC -> sum=0x23456789 unaffected.
// - Assert rst_n=0 after 2 CALC edges -> same cycle: out_val=0, sum=0.
//   After release: in_rdy=1, next op 1+1 -> 2.
// - (SUB_EN) 5 - 7, sub=1 -> sum=0xFFFFFFFE, cout=0; 7 - 5 -> sum=2, cout=1.

Source files
------------

// File: rtl/adder_serial_32b_gl.sv
// Multi-cycle WIDTH-bit adder: one 8-bit carry-select slice reused LSB-first, carry chained through carry_r.
// Optional macro ADDER_SERIAL_SUB_EN adds the sub port (in0 - in1, cout=1 means no borrow).

module AdderCarrySelect_8b_GL (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] r;
        logic       cc;
        cc = c;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[4] = cc;
        return r;
    endfunction

    // Upper nibble is precomputed for both carries; the low nibble's carry selects.
    always_comb begin
        lo  = rca4(a[3:0], b[3:0], cin);
        hi0 = rca4(a[7:4], b[7:4], 1'b0);
        hi1 = rca4(a[7:4], b[7:4], 1'b1);
    end

    assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    assign cout = lo[4] ? hi1[4] : hi0[4];
endmodule

// state | meaning
// IDLE  | in_rdy=1, waiting for operands
// CALC  | one 8-bit slice per edge, idx 0..NSLICE-1
// DONE  | out_val=1, result held until out_rdy
module adder_serial_32b_gl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
`ifdef ADDER_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSLICE = WIDTH / 8;
    localparam int IW     = $clog2(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW+2:0]   base;
    logic [WIDTH-1:0] in0_r;
    logic [WIDTH-1:0] in1_r;
    logic            cin_r;
    logic            carry_r;
    logic            sub_r;
    logic [7:0]      a_s;
    logic [7:0]      b_s;
    logic            c_s;
    logic [7:0]      s_s;
    logic            co_s;

`ifndef ADDER_SERIAL_SUB_EN
    assign sub_r = 1'b0;
`endif

    assign base = {idx, 3'b000};

    // Subtraction is a + ~b + 1, so slice 0 forces carry-in high.
    always_comb begin
        a_s = in0_r[base +: 8];
        b_s = sub_r ? ~in1_r[base +: 8] : in1_r[base +: 8];
        c_s = (idx == '0) ? (sub_r | cin_r) : carry_r;
    end

    AdderCarrySelect_8b_GL u_slice (
        .a   (a_s),
        .b   (b_s),
        .cin (c_s),
        .sum (s_s),
        .cout(co_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_r <= 1'b0;
            in0_r   <= '0;
            in1_r   <= '0;
            cin_r   <= 1'b0;
`ifdef ADDER_SERIAL_SUB_EN
            sub_r   <= 1'b0;
`endif
            sum     <= '0;
            cout    <= 1'b0;
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_val) begin
                        in0_r  <= in0;
                        in1_r  <= in1;
                        cin_r  <= cin;
`ifdef ADDER_SERIAL_SUB_EN
                        sub_r  <= sub;
`endif
                        sum    <= '0;
                        idx    <= '0;
                        in_rdy <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    sum[base +: 8] <= s_s;
                    carry_r        <= co_s;
                    if (idx == LAST) begin
                        cout    <= co_s;
                        idx     <= '0;
                        out_val <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    out_val <= 1'b0;
                    in_rdy  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
